// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the MIPS EX stage: owns HI/LO and
// raises stall while a dependent HI/LO access or a second mul/div must wait.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // partial product high half / partial remainder
  logic [WIDTH-1:0]   q_q, q_d;       // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0]   m_q, m_d;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  logic               op_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] product, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & rs_val[WIDTH-1];
  assign rt_neg    = op_signed & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_val : rs_val;
  assign rt_mag    = rt_neg ? -rt_val : rt_val;

  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
  // Restoring step: a set borrow bit means the trial subtract went negative.
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ok    = ~div_diff[WIDTH];

  assign product   = {acc_q, q_q};
  assign prod_fix  = neg_res_q ? -product : product;
  assign quot_fix  = neg_res_q ? -q_q : q_q;
  assign rem_fix   = neg_rem_q ? -acc_q : acc_q;

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | rd_req | wr_hi | wr_lo);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign div0  = div0_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    div0_d    = div0_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          acc_d     = '0;
          q_d       = rs_mag;
          m_d       = rt_mag;
          is_div_d  = op[1];
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          div0_d    = 1'b0;
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // A zero divisor leaves the dividend magnitude in acc, so rem_fix restores rs.
          lo_d   = (m_q == '0) ? '1 : quot_fix;
          hi_d   = rem_fix;
          div0_d = (m_q == '0);
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: one task per scenario, hand-computed results.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start, rd_req, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wr_data;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div0;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .rd_req(rd_req), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  // Issue one start for one cycle, then count busy cycles until idle (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    tests++;
    if (cycles >= 100) begin
      fails++;
      $display("FAIL op_timeout: busy still high after %0d cycles", cycles);
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo, input logic exp_div0);
    tests++;
    if (hi !== exp_hi || lo !== exp_lo || div0 !== exp_div0) begin
      fails++;
      $display("FAIL %s: got hi=%h lo=%h div0=%b, want hi=%h lo=%h div0=%b",
               name, hi, lo, div0, exp_hi, exp_lo, exp_div0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    rd_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({hi, lo, busy, done, div0, stall} !== '0) begin
      fails++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b div0=%b stall=%b, want all 0",
               hi, lo, busy, done, div0, stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_mult;
    int cyc;
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, cyc);
    tests++;
    if (cyc !== 33) begin
      fails++;
      $display("FAIL mult_latency: busy cycles=%0d, want 33", cyc);
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL mult_done: done=%b when busy drops, want 1", done);
    end
    check_result("mult_7x-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL mult_done_width: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_multu_div;
    int cyc;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    check_result("div_-7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
  endtask

  task automatic test_div_zero;
    int cyc;
    run_op(OP_DIVU, 32'd100, 32'd0, cyc);
    tests++;
    if (cyc !== 33) begin
      fails++;
      $display("FAIL div0_latency: busy cycles=%0d, want 33", cyc);
    end
    check_result("divu_100/0", 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op(OP_MULTU, 32'd3, 32'd5, cyc);
    check_result("multu_3x5_clears_div0", 32'd0, 32'd15, 1'b0);
  endtask

  task automatic test_div_boundary;
    int cyc;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check_result("div_overflow", 32'd0, 32'h8000_0000, 1'b0);
    run_op(OP_DIVU, 32'd25, 32'd3, cyc);
    check_result("divu_25/3", 32'd1, 32'd8, 1'b0);
  endtask

  task automatic test_rd_stall;
    int cyc = 0;
    int bad = 0;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge clk);
    start = 1'b0; rd_req = 1'b1;
    while (busy && cyc < 100) begin
      if (stall !== 1'b1) bad++;
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0 || cyc != 33) begin
      fails++;
      $display("FAIL rd_stall_busy: %0d unstalled cycles over %0d busy cycles, want 0 over 33",
               bad, cyc);
    end
    tests++;
    if (stall !== 1'b0 || lo !== 32'd30) begin
      fails++;
      $display("FAIL rd_stall_release: stall=%b lo=%h, want stall=0 lo=0000001e", stall, lo);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    int bad = 0;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd11;
    @(negedge clk);
    op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd7;
    while (busy && cyc < 100) begin
      if (stall !== 1'b1) bad++;
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0 || cyc != 33) begin
      fails++;
      $display("FAIL b2b_hold_stall: %0d unstalled cycles over %0d busy cycles, want 0 over 33",
               bad, cyc);
    end
    check_result("b2b_first_9x11", 32'd0, 32'd99, 1'b0);
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b after first IDLE cycle, want 1", busy);
    end
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check_result("b2b_second_1000/7", 32'd6, 32'd142, 1'b0);
  endtask

  task automatic test_mtlo;
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'd42;
    @(negedge clk);
    wr_lo = 1'b0;
    check_result("mtlo_42", 32'd6, 32'd42, 1'b0);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check_result("mthi_mtlo_both", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen = 0;
    @(negedge clk);
    start = 1'b1; op = OP_DIV; rs_val = 32'd77; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h done=%b, want 0/0/0/0",
               busy, hi, lo, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      if (done !== 1'b0) seen++;
      @(negedge clk);
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_done: done high %0d cycles after reset, want 0", seen);
    end
    run_op(OP_MULT, 32'd6, 32'd4, cyc);
    check_result("after_reset_6x4", 32'd0, 32'd24, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_div();
    test_div_zero();
    test_div_boundary();
    test_rd_stall();
    test_back_to_back();
    test_mtlo();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
